// File: rtl/data_memory_param.sv
// Byte-addressed little-endian data memory with a valid/ready request port,
// a one-deep response holding stage, alignment and range fault detection,
// a saturating fault counter and a set of word-wide debug probe taps.
module data_memory_param #(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int NUM_PROBE   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      resp_fault,
  output logic [15:0]               fault_count,
  output logic [NUM_PROBE*XLEN-1:0] probe_words
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        mem [DEPTH_BYTES];
  logic [XLEN-1:0]   resp_rdata_reg;
  logic              resp_fault_reg;
  logic [15:0]       fault_count_reg;

  logic              accept;
  logic [3:0]        nbytes;
  logic              size_bad, misalign, range_bad, fault;
  logic [XLEN:0]     end_addr;
  logic [AW-1:0]     byte_idx [NB];
  logic [NB-1:0]     byte_sel;
  logic [7:0]        rd_bytes [NB];
  logic [XLEN-1:0]   load_val;
  logic              sign_bit;

  assign accept    = req_valid && (state_reg == IDLE);
  assign req_ready = (state_reg == IDLE);
  assign resp_valid  = (state_reg == RESP);
  assign resp_rdata  = resp_rdata_reg;
  assign resp_fault  = resp_fault_reg;
  assign fault_count = fault_count_reg;

  // Decode access size and detect every fault condition; the end address is
  // one bit wider than XLEN so a wrap-around near the top cannot hide a fault.
  always_comb begin
    nbytes    = 4'd1 << req_size;
    size_bad  = (req_size == 2'd3) && (XLEN == 32);
    // nbytes[2:0]-1 yields 0,1,3,7 for 1,2,4,8 bytes (8 wraps to 0, minus 1 = 7)
    misalign  = (req_addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
    end_addr  = {1'b0, req_addr} + {{(XLEN-3){1'b0}}, nbytes};
    range_bad = end_addr > (XLEN+1)'(DEPTH_BYTES);
    fault     = size_bad || misalign || range_bad;
  end

  // Per-lane byte address and lane enable; lanes past nbytes are masked off.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign byte_idx[gi] = req_addr[AW-1:0] + AW'(gi);
    assign byte_sel[gi] = 4'(gi) < nbytes;
    assign rd_bytes[gi] = mem[byte_idx[gi]];
  end

  // Assemble the load value and sign- or zero-extend above the accessed bytes.
  always_comb begin
    load_val = '0;
    sign_bit = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (byte_sel[k]) load_val[8*k +: 8] = rd_bytes[k];
      if (4'(k) == nbytes - 4'd1) sign_bit = rd_bytes[k][7];
    end
    if (!req_unsigned && sign_bit) begin
      for (int k = 0; k < NB; k++) begin
        if (!byte_sel[k]) load_val[8*k +: 8] = 8'hFF;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state: accept in IDLE, hold in RESP until the consumer takes it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the response and update the saturating fault counter on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_reg  <= '0;
      resp_fault_reg  <= 1'b0;
      fault_count_reg <= '0;
    end else if (accept) begin
      resp_rdata_reg <= (fault || req_write) ? '0 : load_val;
      resp_fault_reg <= fault;
      if (fault && fault_count_reg != 16'hFFFF)
        fault_count_reg <= fault_count_reg + 16'd1;
    end
  end

  // Memory array: cleared by reset, written byte-wise by non-faulting stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < DEPTH_BYTES; b++) mem[b] <= 8'h00;
    end else if (accept && req_write && !fault) begin
      for (int k = 0; k < NB; k++) begin
        if (byte_sel[k]) mem[byte_idx[k]] <= req_wdata[8*k +: 8];
      end
    end
  end

  // Debug taps: word gi is built from bytes gi*NB .. gi*NB+NB-1.
  for (genvar gi = 0; gi < NUM_PROBE; gi++) begin : g_probe
    for (genvar gj = 0; gj < NB; gj++) begin : g_pbyte
      assign probe_words[gi*XLEN + 8*gj +: 8] = mem[gi*NB + gj];
    end
  end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 SHALL have parameter XLEN, default 64, data word width in bits (32 or 64 only).
REQ-002 SHALL have parameter DEPTH_BYTES, default 256, byte capacity (power of 2, at least NUM_PROBE*XLEN/8).
REQ-003 SHALL have parameter NUM_PROBE, default 8, count of word-aligned debug taps starting at byte 0.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk in, rst_n in.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block can accept a request.
REQ-009 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_addr  input  XLEN  byte address.
REQ-011 SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-012 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-013 SHALL have port req_wdata  input  XLEN  store data, low bytes used.
REQ-014 SHALL have port resp_valid  output  1  response present.
REQ-015 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-016 SHALL have port resp_rdata  output  XLEN  load result; 0 for stores and faults.
REQ-017 SHALL have port resp_fault  output  1  access rejected.
REQ-018 SHALL have port fault_count  output  16  saturating count of faulted requests.
REQ-019 SHALL have port probe_words  output  NUM_PROBE*XLEN  word i at bits [i*XLEN +: XLEN], read from bytes starting at i*XLEN/8.

Function
REQ-020 SHALL implement an FSM with two states, IDLE and RESP; req_ready = (state == IDLE); resp_valid = (state == RESP).
REQ-021 SHALL accept a request on a rising edge with req_valid and req_ready both high, then enter RESP on that same edge, giving a latency of 1 cycle.
REQ-022 SHALL hold resp_valid, resp_rdata and resp_fault stable in RESP until a rising edge with resp_ready high, then return to IDLE; no new request is accepted in RESP.
REQ-023 SHALL compute nbytes = 1 << req_size, with memory organised little-endian: byte addr+k maps to data bits [8k+7:8k].
REQ-024 SHALL flag a fault on any of: req_size == 3 with XLEN == 32; req_addr mod nbytes != 0; req_addr + nbytes > DEPTH_BYTES, evaluated without overflow at full XLEN width.
REQ-025 SHALL leave memory unmodified on a faulting store, set resp_rdata to 0, and increment fault_count, saturating at 16'hFFFF.
REQ-026 SHALL, on an accepted non-faulting store, write bytes req_addr..req_addr+nbytes-1 from req_wdata[8*nbytes-1:0] at the accepting edge, leaving all other bytes unchanged.
REQ-027 SHALL, on an accepted non-faulting load, register the nbytes bytes as they were before that edge, then sign- or zero-extend them to XLEN per req_unsigned (req_unsigned is ignored when nbytes*8 == XLEN).
REQ-028 SHALL drive probe_words combinationally from memory, reflecting a store from the cycle after its accepting edge.
REQ-029 SHALL ignore req_* inputs whenever no request is accepted.

Reset
REQ-030 SHALL, while rst_n is low, force state = IDLE, resp_valid = 0, resp_rdata = 0, resp_fault = 0, fault_count = 0, all memory bytes = 0, so probe_words = 0 and req_ready = 1 after release.
REQ-031 SHALL, if reset asserts in RESP, discard the pending response and take no further action; a store accepted before reset is also cleared.

Verification
REQ-032 SHALL pass: store size 3, addr 0x10, wdata 64'h8877665544332211, then load size 3 addr 0x10 -> rdata 64'h8877665544332211, fault 0, probe word 2 equals the stored value.
REQ-033 SHALL pass: store byte 8'h80 at addr 0x05, then load size 0 signed -> 64'hFFFFFFFFFFFFFF80; load unsigned -> 64'h80; bytes 0x04 and 0x06 unchanged.
REQ-034 SHALL pass: load size 2 at addr 0x06 -> fault 1, rdata 0, fault_count 1; store size 1 at addr DEPTH_BYTES-1 -> fault 1, memory unchanged, fault_count 2.
REQ-035 SHALL pass: hold resp_ready low 5 cycles after a load -> resp_valid, rdata and fault stable and req_ready 0 throughout; raise resp_ready -> IDLE on the next edge.
REQ-036 SHALL pass: pulse rst_n low while in RESP after a store -> resp_valid 0, memory and probe_words all 0, fault_count 0, req_ready 1.
REQ-037 SHALL pass: with XLEN=32, a size-3 request -> fault 1; a size-2 load of 32'h80000000 -> 32'h80000000, with no extension performed.
